nexys_starship_spawn_gen: RTL and testbench



---
 rtl/nexys_starship_spawn_gen.sv | 155 +++++++++++++++
 tb/tb_nexys_starship_spawn_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_spawn_gen.sv
// Multi-channel Galois-LFSR spawn generator with per-channel request/acknowledge handshake.
// Optional per-channel cooldown is compiled in when NEXYS_SPAWN_COOLDOWN_EN is defined.
module nexys_starship_spawn_gen #(
    parameter int         NCH       = 4,
    parameter int         WIDTH     = 8,
    parameter logic [7:0] SEED_BASE = 8'hA5,
    parameter int         COOLDOWN  = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Tick,
    input  logic             Enable,
    input  logic [WIDTH-1:0] Threshold,
    input  logic [NCH-1:0]   Ack,
    output logic [NCH-1:0]   Req,
    output logic [NCH-1:0]   Busy
);

    localparam logic [31:0] MASK_FULL = (WIDTH == 8)  ? 32'h0000_00B8 :
                                        (WIDTH == 16) ? 32'h0000_B400 :
                                                        32'h8020_0003;
    localparam logic [WIDTH-1:0] MASK = MASK_FULL[WIDTH-1:0];

    generate
        if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
            $error("nexys_starship_spawn_gen: WIDTH must be 8, 16 or 32");
        end
        if (NCH < 1 || NCH > 8) begin : g_bad_nch
            $error("nexys_starship_spawn_gen: NCH must be 1..8");
        end
`ifdef NEXYS_SPAWN_COOLDOWN_EN
        if (COOLDOWN < 1 || COOLDOWN > 255) begin : g_bad_cool
            $error("nexys_starship_spawn_gen: COOLDOWN must be 1..255");
        end
`endif
    endgenerate

    // Per-channel seed; a zero seed would lock the LFSR, so it is forced to 1.
    function automatic logic [WIDTH-1:0] seed_of(input int idx);
        logic [WIDTH-1:0] s;
        s = WIDTH'(SEED_BASE) + WIDTH'(32'd37 * idx);
        return (s == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : s;
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {1'b0, s[WIDTH-1:1]} ^ (s[0] ? MASK : {WIDTH{1'b0}});
    endfunction

`ifdef NEXYS_SPAWN_COOLDOWN_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_COOL = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1
    } state_t;
`endif

    state_t           state_r [NCH];
    state_t           state_s [NCH];
    logic [WIDTH-1:0] lfsr_r  [NCH];
    logic [WIDTH-1:0] lfsr_s  [NCH];
    logic [NCH-1:0]   hit_s;
    logic [NCH-1:0]   req_r;
    logic [NCH-1:0]   busy_r;
`ifdef NEXYS_SPAWN_COOLDOWN_EN
    logic [7:0]       cnt_r   [NCH];
    logic [7:0]       cnt_s   [NCH];
`endif

    // Next-state logic: LFSR stepping, hit detection and per-channel handshake FSM.
    always_comb begin
        hit_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            state_s[i] = state_r[i];
            lfsr_s[i]  = Tick ? lfsr_step(lfsr_r[i]) : lfsr_r[i];
            hit_s[i]   = Tick && Enable && (lfsr_s[i] < Threshold);
`ifdef NEXYS_SPAWN_COOLDOWN_EN
            cnt_s[i]   = cnt_r[i];
`endif
            case (state_r[i])
                ST_IDLE: begin
                    if (hit_s[i]) begin
                        state_s[i] = ST_REQ;
                    end else begin
                        state_s[i] = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // Ack beats a coincident Tick; the loaded count is not decremented here.
                    if (Ack[i]) begin
`ifdef NEXYS_SPAWN_COOLDOWN_EN
                        state_s[i] = ST_COOL;
                        cnt_s[i]   = 8'(COOLDOWN);
`else
                        state_s[i] = ST_IDLE;
`endif
                    end else begin
                        state_s[i] = ST_REQ;
                    end
                end
`ifdef NEXYS_SPAWN_COOLDOWN_EN
                ST_COOL: begin
                    if (Tick) begin
                        if (cnt_r[i] <= 8'd1) begin
                            state_s[i] = ST_IDLE;
                            cnt_s[i]   = 8'd0;
                        end else begin
                            state_s[i] = ST_COOL;
                            cnt_s[i]   = cnt_r[i] - 8'd1;
                        end
                    end else begin
                        state_s[i] = ST_COOL;
                    end
                end
`endif
                default: begin
                    state_s[i] = ST_IDLE;
                end
            endcase
        end
    end

    // State, LFSR and registered output update with synchronous reset priority.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NCH; i++) begin
                lfsr_r[i]  <= seed_of(i);
                state_r[i] <= ST_IDLE;
`ifdef NEXYS_SPAWN_COOLDOWN_EN
                cnt_r[i]   <= 8'd0;
`endif
            end
            req_r  <= {NCH{1'b0}};
            busy_r <= {NCH{1'b0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                lfsr_r[i]  <= lfsr_s[i];
                state_r[i] <= state_s[i];
`ifdef NEXYS_SPAWN_COOLDOWN_EN
                cnt_r[i]   <= cnt_s[i];
`endif
                req_r[i]   <= (state_s[i] == ST_REQ);
                busy_r[i]  <= (state_s[i] != ST_IDLE);
            end
        end
    end

    assign Req  = req_r;
    assign Busy = busy_r;

endmodule

// File: tb/tb_nexys_starship_spawn_gen.sv
// Directed, table-driven bench for nexys_starship_spawn_gen (NCH=4, WIDTH=8, COOLDOWN=3).
// Expectations for the cooldown build follow NEXYS_SPAWN_COOLDOWN_EN.
module tb_nexys_starship_spawn_gen;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Tick;
    logic       Enable;
    logic [7:0] Threshold;
    logic [3:0] Ack;
    logic [3:0] Req;
    logic [3:0] Busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    nexys_starship_spawn_gen #(
        .NCH       (4),
        .WIDTH     (8),
        .SEED_BASE (8'hA5),
        .COOLDOWN  (3)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Tick      (Tick),
        .Enable    (Enable),
        .Threshold (Threshold),
        .Ack       (Ack),
        .Req       (Req),
        .Busy      (Busy)
    );

    typedef struct {
        string      name;
        logic       pre;
        logic       en;
        logic [7:0] thr;
        logic [3:0] req;
    } vec_t;

    vec_t vecs [12];

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle from a negedge; returns at the next negedge, ready to sample.
    task automatic cyc(input logic t, input logic [3:0] a);
        Tick = t;
        Ack  = a;
        @(negedge Clk);
        Tick = 1'b0;
        Ack  = 4'b0000;
    endtask

    task automatic do_reset(input int n);
        Reset = 1'b1;
        repeat (n) cyc(1'b0, 4'b0000);
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Seeds A5 CA EF 14 -> first step EA 65 CF 0A -> second step 75 8A DF 05.
        vecs[0]  = '{"thr70",     1'b0, 1'b1, 8'h70, 4'b1010};
        vecs[1]  = '{"thrF0",     1'b0, 1'b1, 8'hF0, 4'b1111};
        vecs[2]  = '{"thr00",     1'b0, 1'b1, 8'h00, 4'b0000};
        vecs[3]  = '{"enable0",   1'b0, 1'b0, 8'hF0, 4'b0000};
        vecs[4]  = '{"adv_thr80", 1'b1, 1'b1, 8'h80, 4'b1001};
        vecs[5]  = '{"thrFF",     1'b0, 1'b1, 8'hFF, 4'b1111};
        vecs[6]  = '{"thr0A",     1'b0, 1'b1, 8'h0A, 4'b0000};
        vecs[7]  = '{"thr0B",     1'b0, 1'b1, 8'h0B, 4'b1000};
        vecs[8]  = '{"thr66",     1'b0, 1'b1, 8'h66, 4'b1010};
        vecs[9]  = '{"thr65",     1'b0, 1'b1, 8'h65, 4'b1000};
        vecs[10] = '{"adv_thrE0", 1'b1, 1'b1, 8'hE0, 4'b1111};
        vecs[11] = '{"adv_thrDF", 1'b1, 1'b1, 8'hDF, 4'b1011};

        Reset     = 1'b1;
        Tick      = 1'b0;
        Enable    = 1'b0;
        Threshold = 8'h00;
        Ack       = 4'b0000;
        @(negedge Clk);

        do_reset(2);
        check4("reset_req", Req, 4'b0000);
        check4("reset_busy", Busy, 4'b0000);

        // Tick and Ack during reset must be ignored.
        Reset     = 1'b1;
        Enable    = 1'b1;
        Threshold = 8'hFF;
        cyc(1'b1, 4'b1111);
        Reset = 1'b0;
        check4("reset_prio_req", Req, 4'b0000);
        Threshold = 8'h70;
        cyc(1'b1, 4'b0000);
        check4("reset_prio_seq", Req, 4'b1010);

        for (int k = 0; k < 12; k++) begin
            do_reset(1);
            if (vecs[k].pre) begin
                Enable    = 1'b0;
                Threshold = 8'hFF;
                cyc(1'b1, 4'b0000);
                check4({vecs[k].name, "_pre"}, Req, 4'b0000);
            end else begin
                Enable = 1'b1;
            end
            Enable    = vecs[k].en;
            Threshold = vecs[k].thr;
            cyc(1'b1, 4'b0000);
            check4({vecs[k].name, "_req"}, Req, vecs[k].req);
            check4({vecs[k].name, "_busy"}, Busy, vecs[k].req);
        end

        // Handshake: request held through many Ticks, stray Ack ignored.
        do_reset(1);
        Enable    = 1'b1;
        Threshold = 8'h70;
        cyc(1'b1, 4'b0000);
        check4("hs_req", Req, 4'b1010);
        Threshold = 8'h00;
        repeat (20) cyc(1'b1, 4'b0000);
        check4("hs_hold_req", Req, 4'b1010);
        check4("hs_hold_busy", Busy, 4'b1010);
        cyc(1'b0, 4'b0001);
        check4("hs_stray_ack_req", Req, 4'b1010);
        check4("hs_stray_ack_busy", Busy, 4'b1010);
        cyc(1'b0, 4'b0010);
        check4("hs_ack_req", Req, 4'b1000);
`ifdef NEXYS_SPAWN_COOLDOWN_EN
        check4("hs_ack_busy", Busy, 4'b1010);
`else
        check4("hs_ack_busy", Busy, 4'b1000);
`endif
        cyc(1'b1, 4'b0000);
        check4("hs_no_queue_req", Req, 4'b1000);

        // Cooldown with Ack coincident with Tick on channel 0.
        do_reset(1);
        Enable    = 1'b1;
        Threshold = 8'hFF;
        cyc(1'b1, 4'b0000);
        check4("cd_all_req", Req, 4'b1111);
        cyc(1'b1, 4'b0001);
`ifdef NEXYS_SPAWN_COOLDOWN_EN
        check4("cd_ack_req", Req, 4'b1110);
        check4("cd_ack_busy", Busy, 4'b1111);
        cyc(1'b1, 4'b0000);
        check4("cd_t1_busy", Busy, 4'b1111);
        cyc(1'b1, 4'b0000);
        check4("cd_t2_busy", Busy, 4'b1111);
        cyc(1'b1, 4'b0000);
        check4("cd_t3_req", Req, 4'b1110);
        check4("cd_t3_busy", Busy, 4'b1110);
        cyc(1'b1, 4'b0000);
        check4("cd_t4_req", Req, 4'b1111);
        cyc(1'b0, 4'b0001);
        check4("mid_cool_busy", Busy, 4'b1111);
`else
        check4("cd_ack_req", Req, 4'b1110);
        check4("cd_ack_busy", Busy, 4'b1110);
        cyc(1'b1, 4'b0000);
        check4("cd_t1_req", Req, 4'b1111);
        check4("cd_t1_busy", Busy, 4'b1111);
        cyc(1'b0, 4'b0001);
        check4("mid_idle_busy", Busy, 4'b1110);
`endif

        // Reset mid-operation restores seeds and replays the same sequence.
        do_reset(1);
        check4("mid_reset_req", Req, 4'b0000);
        check4("mid_reset_busy", Busy, 4'b0000);
        Enable    = 1'b1;
        Threshold = 8'h70;
        cyc(1'b1, 4'b0000);
        check4("replay1_req", Req, 4'b1010);
        cyc(1'b0, 4'b1010);
        Threshold = 8'h80;
        cyc(1'b1, 4'b0000);
`ifdef NEXYS_SPAWN_COOLDOWN_EN
        check4("replay2_req", Req, 4'b0001);
        check4("replay2_busy", Busy, 4'b1011);
`else
        check4("replay2_req", Req, 4'b1001);
        check4("replay2_busy", Busy, 4'b1001);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
